// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary GCD engine.
// Provides the FSM state enum and the width rule for the power-of-two counter.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // k counts common factors of two; at most WIDTH of them exist.
  function automatic int k_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational reduction step of Stein's binary GCD.
// Ports: ra, rb in; ra_next, rb_next, k_inc (common factor 2 removed), term (an operand is zero).
module gcd_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic [WIDTH-1:0] ra_next,
  output logic [WIDTH-1:0] rb_next,
  output logic             k_inc,
  output logic             term
);

  logic ra_zero;
  logic rb_zero;
  logic ra_even;
  logic rb_even;
  logic ra_ge;

  assign ra_zero = (ra == '0);
  assign rb_zero = (rb == '0);
  assign ra_even = ~ra[0];
  assign rb_even = ~rb[0];
  assign ra_ge   = (ra >= rb);

  always_comb begin
    ra_next = ra;
    rb_next = rb;
    k_inc   = 1'b0;
    term    = 1'b0;
    if (ra_zero || rb_zero) begin
      term = 1'b1;
    end else if (ra_even && rb_even) begin
      ra_next = ra >> 1;
      rb_next = rb >> 1;
      k_inc   = 1'b1;
    end else if (ra_even) begin
      ra_next = ra >> 1;
    end else if (rb_even) begin
      rb_next = rb >> 1;
    end else if (ra_ge) begin
      ra_next = (ra - rb) >> 1;
    end else begin
      // Swap so the smaller odd value stays in rb.
      ra_next = (rb - ra) >> 1;
      rb_next = ra;
    end
  end

endmodule

// File: rtl/binary_gcd_engine.sv
// Multi-cycle Stein GCD engine with start/busy/done handshake and registered result.
// Ports: clk, reset (async, active-high), start, a, b in; busy, done, gcd out. Option macro: GCD_SIGNED_EN.
module binary_gcd_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd
);

  import gcd_pkg::*;

  localparam int KW = k_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] ra_nx;
  logic [WIDTH-1:0] rb_nx;
  logic [WIDTH-1:0] res;
  logic             k_inc;
  logic             term;

`ifdef GCD_SIGNED_EN
  // Negating the most negative value wraps to 2^(WIDTH-1), its true magnitude.
  assign a_in = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_in = b[WIDTH-1] ? (~b + 1'b1) : b;
`else
  assign a_in = a;
  assign b_in = b;
`endif

  gcd_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .ra      (ra),
    .rb      (rb),
    .ra_next (ra_nx),
    .rb_next (rb_nx),
    .k_inc   (k_inc),
    .term    (term)
  );

  assign res = (ra == '0) ? rb : ra;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      gcd   <= '0;
      ra    <= '0;
      rb    <= '0;
      k     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a_in;
            rb    <= b_in;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (term) begin
            gcd   <= res << k;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            ra <= ra_nx;
            rb <= rb_nx;
            if (k_inc) k <= k + KW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_gcd_engine.sv
// Self-checking bench for binary_gcd_engine (WIDTH=16).
// Table-driven vectors plus hand sequences for abort, ignored start and back-to-back use.
module tb_binary_gcd_engine;

  localparam int W    = 16;
  localparam int LMAX = 2 * W + 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] gcd;

  int pass_cnt;
  int tot_cnt;

  binary_gcd_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gcd   (gcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    tot_cnt++;
    if (act <= lim) pass_cnt++;
    else $display("FAIL %s: got %0d expected <= %0d", name, act, lim);
  endtask

  // Drive start for one edge; returns after the accepting edge (#1 later).
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done; lat counts edges from the accepting edge (accept edge = 1).
  task automatic wait_done(input string name, output int lat, output bit bad_busy);
    lat      = 1;
    bad_busy = 1'b0;
    while (!done && lat <= LMAX + 4) begin
      if (!busy) bad_busy = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int  lat;
    bit  bb;
    pass_cnt = 0;
    tot_cnt  = 0;
    reset    = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    vecs[0] = '{16'd48,    16'd18,    16'd6,    0};
    vecs[1] = '{16'd0,     16'd35,    16'd35,   2};
    vecs[2] = '{16'd0,     16'd0,     16'd0,    2};
    vecs[3] = '{16'd35,    16'd0,     16'd35,   2};
    vecs[4] = '{16'd1024,  16'd4096,  16'd1024, 0};
    vecs[5] = '{16'd65535, 16'd65534, 16'd1,    0};
    vecs[6] = '{16'd12,    16'd8,     16'd4,    0};
    vecs[7] = '{16'd7,     16'd21,    16'd7,    0};
`ifdef GCD_SIGNED_EN
    vecs[8] = '{16'hFFD0,  16'd18,    16'd6,    0};
    vecs[9] = '{16'h8000,  16'd0,     16'h8000, 2};
`else
    vecs[8] = '{16'hFFD0,  16'd18,    16'd2,    0};
    vecs[9] = '{16'h8000,  16'd0,     16'h8000, 2};
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gcd", gcd, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].va, vecs[i].vb);
      check($sformatf("v%0d_busy_on", i), busy, 1);
      wait_done($sformatf("v%0d", i), lat, bb);
      check($sformatf("v%0d_gcd", i), gcd, vecs[i].exp);
      check($sformatf("v%0d_busy_run", i), bb, 0);
      check($sformatf("v%0d_busy_done", i), busy, 0);
      if (vecs[i].lat != 0) check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      else check_le($sformatf("v%0d_lat", i), lat, LMAX);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_gcd_hold", i), gcd, vecs[i].exp);
    end

    // Start re-pulsed during RUN must be ignored.
    issue(16'd48, 16'd18);
    @(negedge clk);
    a     = 16'd7;
    b     = 16'd21;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", lat, bb);
    check("ign_gcd", gcd, 6);

    // Start held in the DONE cycle: accepted, old result held until rewrite.
    a     = 16'd7;
    b     = 16'd21;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    check("b2b_hold", gcd, 6);
    lat = 1;
    bb  = 1'b0;
    while (!done && lat <= LMAX + 4) begin
      if (gcd != 16'd6) bb = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_hold_run", bb, 0);
    check("b2b_gcd", gcd, 7);
    check("b2b_done", done, 1);

    // Reset mid-RUN aborts with no done pulse.
    @(posedge clk);
    issue(16'd65535, 16'd65534);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_gcd", gcd, 0);
    @(negedge clk);
    reset = 1'b0;
    bb = 1'b0;
    repeat (LMAX) begin
      @(posedge clk);
      #1;
      if (done || busy) bb = 1'b1;
    end
    check("abort_quiet", bb, 0);
    issue(16'd12, 16'd8);
    wait_done("post", lat, bb);
    check("post_gcd", gcd, 4);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
